// File: rtl/ram_arbiter.sv
// Shares one 64-bit RAMHelper port between instruction fetch and the LSU.
// One grant per cycle, combinational in the request cycle; responses follow one cycle later.
module ram_arbiter #(
   parameter logic [63:0] PC_START = 64'h0000_0000_8000_0000,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [63:0] mem_addr,
   input  logic [1:0]  mem_size,
   input  logic [63:0] mem_wdata,
   output logic        mem_gnt,
   output logic        mem_rvalid,
   output logic [63:0] mem_rdata,
   output logic        mem_err,
   output logic        ram_en,
   output logic [63:0] ram_ridx,
   input  logic [63:0] ram_rdata,
   output logic        ram_wen,
   output logic [63:0] ram_widx,
   output logic [63:0] ram_wdata,
   output logic [63:0] ram_wmask
);

   localparam int unsigned CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_MEM,
      OWN_ERR
   } owner_t;

   owner_t          owner_q, owner_d;
   logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
   logic            if_hi_q, if_hi_d;
   logic [2:0]      off_q, off_d;
   logic [1:0]      size_q, size_d;

   logic            if_win, mem_win, mem_mis;
   logic [2:0]      mem_off;
   logic [5:0]      wr_shamt;
   logic [63:0]     sel_addr, idx, rd_shift;

   function automatic logic [63:0] size_mask(input logic [1:0] s);
      case (s)
         2'd0:    size_mask = 64'h0000_0000_0000_00FF;
         2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
         2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
         default: size_mask = '1;
      endcase
   endfunction

   // Arbitration and RAM request side
   always_comb begin
      if_win   = rst & if_req & (~mem_req | (wait_cnt_q >= CW'(MAX_WAIT)));
      mem_win  = rst & mem_req & ~if_win;
      mem_off  = mem_addr[2:0];
      case (mem_size)
         2'd0:    mem_mis = 1'b0;
         2'd1:    mem_mis = mem_off[0];
         2'd2:    mem_mis = |mem_off[1:0];
         default: mem_mis = |mem_off;
      endcase
      sel_addr = if_win ? if_addr : mem_addr;
      idx      = (sel_addr - PC_START) >> 3;
      wr_shamt = {mem_off, 3'b000};

      if_gnt    = if_win;
      mem_gnt   = mem_win;
      ram_en    = 1'b0;
      ram_ridx  = '0;
      ram_wen   = 1'b0;
      ram_widx  = '0;
      ram_wdata = '0;
      ram_wmask = '0;
      if (if_win || (mem_win && !mem_we && !mem_mis)) begin
         ram_en   = 1'b1;
         ram_ridx = idx;
      end
      if (mem_win && mem_we && !mem_mis) begin
         ram_wen   = 1'b1;
         ram_widx  = idx;
         ram_wdata = mem_wdata << wr_shamt;
         ram_wmask = size_mask(mem_size) << wr_shamt;
      end
   end

   // Next-state: starvation counter and response owner
   always_comb begin
      if (!if_req || if_win)
         wait_cnt_d = '0;
      else if (wait_cnt_q < CW'(MAX_WAIT))
         wait_cnt_d = wait_cnt_q + CW'(1);
      else
         wait_cnt_d = wait_cnt_q;

      owner_d = OWN_NONE;
      if_hi_d = if_hi_q;
      off_d   = off_q;
      size_d  = size_q;
      if (if_win) begin
         owner_d = OWN_IF;
         if_hi_d = if_addr[2];
      end else if (mem_win) begin
         off_d  = mem_off;
         size_d = mem_size;
         if (mem_mis)
            owner_d = OWN_ERR;
         else if (!mem_we)
            owner_d = OWN_MEM;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner_q    <= OWN_NONE;
         wait_cnt_q <= '0;
         if_hi_q    <= 1'b0;
         off_q      <= '0;
         size_q     <= '0;
      end else begin
         owner_q    <= owner_d;
         wait_cnt_q <= wait_cnt_d;
         if_hi_q    <= if_hi_d;
         off_q      <= off_d;
         size_q     <= size_d;
      end
   end

   // Responses are qualified by rst so a reset cycle never shows a stale response.
   always_comb begin
      rd_shift   = ram_rdata >> {off_q, 3'b000};
      if_rvalid  = rst & (owner_q == OWN_IF);
      if_rdata   = '0;
      if (if_rvalid)
         if_rdata = if_hi_q ? ram_rdata[63:32] : ram_rdata[31:0];
      mem_rvalid = rst & ((owner_q == OWN_MEM) | (owner_q == OWN_ERR));
      mem_err    = rst & (owner_q == OWN_ERR);
      mem_rdata  = '0;
      if (rst && owner_q == OWN_MEM)
         mem_rdata = rd_shift & size_mask(size_q);
   end

endmodule
